// File: rtl/output_display_pkg.sv
// Shared types and constants for the output_display port.
// Holds the FSM state encoding, active-low 7-segment codes (gfedcba)
// and the powers-of-ten table used for the overflow compare.
package output_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Active-low segments, bit order gfedcba; all ones is a dark digit.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // POW10[n] is the smallest value that no longer fits in n decimal digits.
  localparam logic [31:0] POW10 [0:9] = '{
    32'd1,
    32'd10,
    32'd100,
    32'd1000,
    32'd10000,
    32'd100000,
    32'd1000000,
    32'd10000000,
    32'd100000000,
    32'd1000000000
  };

endpackage

// File: rtl/output_display_if.sv
// Bus between the processor OUT path and the display port.
// master = processor side (drives strobe/data), slave = display port.
// NUM_DIGITS must match the value used by the attached output_display.
interface output_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    out;
  logic [31:0]             data;
  logic                    busy;
  logic [7*NUM_DIGITS-1:0] hex;
  logic                    overflow;
  logic                    negative;

  modport master (
    output out, data,
    input  busy, hex, overflow, negative
  );

  modport slave (
    input  out, data,
    output busy, hex, overflow, negative
  );
endinterface

// File: rtl/output_display_seg7_decoder.sv
// BCD nibble to active-low 7-segment code (gfedcba), purely combinational.
// Codes 10..15 are not decimal digits and leave the digit dark.
module seg7_decoder
  import output_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup; anything outside 0..9 blanks the digit.
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/output_display.sv
// Display output port: captures a word on a strobe, converts it to decimal
// with shift-add-3 (one bit per clock) and drives active-low 7-seg digits.
// Latency: 33 edges from capture to display update; strobes while busy are dropped.
// Optional feature macro: SIGNED_DISPLAY_EN (two's complement input, sign flag).
module output_display
  import output_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,   // 1..9
  parameter int DATA_WIDTH = 32   // fixed at 32
) (
  input  logic                clock,
  input  logic                reset_n,
  output_display_if.slave     bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int HEX_W = 7 * NUM_DIGITS;
  localparam logic [4:0] LAST_BIT = 5'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
  logic [4:0]            cnt_q, cnt_d;
  logic [HEX_W-1:0]      hex_q, hex_d, seg_dec;
  logic                  ovf_pend_q, ovf_pend_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] magnitude;

`ifdef SIGNED_DISPLAY_EN
  logic                  neg_pend_q, neg_pend_d;
  logic                  neg_q, neg_d;
  // -0x80000000 wraps to itself, which as unsigned is the correct magnitude.
  assign magnitude = bus.data[DATA_WIDTH-1] ? -bus.data : bus.data;
`else
  assign magnitude = bus.data;
`endif

  // One digit decoder per displayed digit, fed from the finished BCD register.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .bcd_i (bcd_q[4*g +: 4]),
      .seg_o (seg_dec[7*g +: 7])
    );
  end

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath updates for the IDLE -> CONVERT -> DONE sequence.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    hex_d      = hex_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`ifdef SIGNED_DISPLAY_EN
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.out) begin
          shift_d    = magnitude;
          bcd_d      = '0;
          cnt_d      = '0;
          // Overflow is judged on the full magnitude before digits are lost.
          ovf_pend_d = (magnitude >= POW10[NUM_DIGITS]);
`ifdef SIGNED_DISPLAY_EN
          neg_pend_d = bus.data[DATA_WIDTH-1];
`endif
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        // Bit shifted out of the top nibble is dropped: result is mod 10**NUM_DIGITS.
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[DATA_WIDTH-1]};
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Only edge at which the visible outputs change after reset.
        hex_d   = seg_dec;
        ovf_d   = ovf_pend_q;
`ifdef SIGNED_DISPLAY_EN
        neg_d   = neg_pend_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset blanks the display.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      hex_q      <= '1;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      hex_q      <= hex_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`ifdef SIGNED_DISPLAY_EN
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
`endif
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.hex      = hex_q;
  assign bus.overflow = ovf_q;
`ifdef SIGNED_DISPLAY_EN
  assign bus.negative = neg_q;
`else
  assign bus.negative = 1'b0;
`endif

endmodule

// File: tb/tb_output_display.sv
// Self-checking bench for output_display with NUM_DIGITS = 4.
// Expected display words come from a decimal model pushed to a scoreboard at each strobe.
// Checks reset, conversions, boundaries, dropped strobes, back-to-back and mid-conversion reset.
module tb_output_display;

  localparam int ND = 4;
  localparam int HW = 7 * ND;

  typedef struct packed {
    logic [HW-1:0] hex;
    logic          ovf;
    logic          neg;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  exp_t sb[$];

  output_display_if #(.NUM_DIGITS(ND)) dif ();

  output_display #(.NUM_DIGITS(ND), .DATA_WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] d);
    exp_t        e;
    logic [31:0] mag;
    int unsigned v;
    e   = '0;
    mag = d;
`ifdef SIGNED_DISPLAY_EN
    if (d[31]) begin
      mag   = -d;
      e.neg = 1'b1;
    end
`endif
    e.ovf = (mag >= 32'd10000);
    v = mag % 10000;
    for (int i = 0; i < ND; i++) begin
      e.hex[7*i +: 7] = seg_of(v % 10);
      v = v / 10;
    end
    return e;
  endfunction

  // Called #1 after a posedge; returns #1 after the capturing edge E0.
  task automatic strobe(input logic [31:0] d);
    dif.out  = 1'b1;
    dif.data = d;
    sb.push_back(model(d));
    @(posedge clock); #1;
    dif.out = 1'b0;
  endtask

  // Counts edges until busy drops, bounded so a stuck DUT still terminates.
  task automatic wait_idle(output int n);
    n = 0;
    while (dif.busy === 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    dif.out  = 1'b0;
    dif.data = '0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (dif.hex !== {HW{1'b1}}) begin
      errors++; $display("FAIL reset_hex_during: got %h expected %h", dif.hex, {HW{1'b1}});
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (dif.hex !== 28'hFFFFFFF) begin
      errors++; $display("FAIL reset_hex: got %h expected %h", dif.hex, 28'hFFFFFFF);
    end
    checks++;
    if ({dif.busy, dif.overflow, dif.negative} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/ovf/neg=%b expected 000",
                         {dif.busy, dif.overflow, dif.negative});
    end
  endtask

  task automatic test_basic();
    int   n;
    exp_t e;
    strobe(32'd1234);
    checks++;
    if (dif.busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_rise: got %b expected 1", dif.busy);
    end
    wait_idle(n);
    checks++;
    if (n != 33) begin
      errors++; $display("FAIL basic_latency: got %0d edges expected 33", n);
    end
    e = sb.pop_front();
    checks++;
    if (dif.hex !== {7'h79, 7'h24, 7'h30, 7'h19}) begin
      errors++; $display("FAIL basic_hex_1234: got %h expected %h", dif.hex, {7'h79, 7'h24, 7'h30, 7'h19});
    end
    checks++;
    if ({dif.hex, dif.overflow, dif.negative} !== {e.hex, e.ovf, e.neg}) begin
      errors++; $display("FAIL basic_sb: got %h/%b/%b expected %h/%b/%b",
                         dif.hex, dif.overflow, dif.negative, e.hex, e.ovf, e.neg);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] vals [6];
    int          n;
    exp_t        e;
    vals = '{32'd12345, 32'd9999, 32'd0, 32'd10000, 32'hFFFFFFFF, 32'd8021};
    foreach (vals[k]) begin
      strobe(vals[k]);
      wait_idle(n);
      checks++;
      if (n != 33) begin
        errors++; $display("FAIL bound_latency[%0d]: got %0d expected 33", k, n);
      end
      e = sb.pop_front();
      checks++;
      if (dif.hex !== e.hex) begin
        errors++; $display("FAIL bound_hex[%0d]: got %h expected %h", k, dif.hex, e.hex);
      end
      checks++;
      if ({dif.overflow, dif.negative} !== {e.ovf, e.neg}) begin
        errors++; $display("FAIL bound_flags[%0d]: got ovf/neg=%b%b expected %b%b",
                           k, dif.overflow, dif.negative, e.ovf, e.neg);
      end
    end
  endtask

  task automatic test_busy_strobe();
    int            n;
    exp_t          e;
    logic [HW-1:0] prev;
    prev = dif.hex;
    strobe(32'd7);
    repeat (9) @(posedge clock);
    #1;
    dif.out  = 1'b1;
    dif.data = 32'd5;
    @(posedge clock); #1;
    dif.out  = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (dif.hex !== prev) begin
      errors++; $display("FAIL busy_hex_held: got %h expected %h", dif.hex, prev);
    end
    wait_idle(n);
    checks++;
    if (n != 13) begin
      errors++; $display("FAIL busy_fall_edge: got %0d more edges expected 13 (E33)", n);
    end
    e = sb.pop_front();
    checks++;
    if ({dif.hex, dif.overflow} !== {e.hex, e.ovf}) begin
      errors++; $display("FAIL busy_result: got %h/%b expected %h/%b", dif.hex, dif.overflow, e.hex, e.ovf);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++; $display("FAIL busy_no_queue: got busy=%b expected 0", dif.busy);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    exp_t e;
    strobe(32'd42);
    dif.out = 1'b1;
    wait_idle(n);
    checks++;
    if (n != 33) begin
      errors++; $display("FAIL b2b_latency0: got %0d expected 33", n);
    end
    e = sb.pop_front();
    checks++;
    if (dif.hex !== e.hex) begin
      errors++; $display("FAIL b2b_hex0: got %h expected %h", dif.hex, e.hex);
    end
    dif.data = 32'd58;
    sb.push_back(model(32'd58));
    @(posedge clock); #1;
    dif.out = 1'b0;
    checks++;
    if (dif.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: got busy=%b expected 1", dif.busy);
    end
    wait_idle(n);
    e = sb.pop_front();
    checks++;
    if (dif.hex !== e.hex || n != 33) begin
      errors++; $display("FAIL b2b_hex1: got %h after %0d edges expected %h after 33", dif.hex, n, e.hex);
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    exp_t e;
    strobe(32'd9876);
    repeat (14) @(posedge clock);
    #1;
    checks++;
    if (dif.busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy_before: got %b expected 1", dif.busy);
    end
    @(posedge clock); #1;
    reset_n = 1'b0;
    void'(sb.pop_front());
    #1;
    checks++;
    if ({dif.hex, dif.busy, dif.overflow, dif.negative} !== {{HW{1'b1}}, 3'b000}) begin
      errors++; $display("FAIL mid_reset_values: got %h/%b%b%b expected %h/000",
                         dif.hex, dif.busy, dif.overflow, dif.negative, {HW{1'b1}});
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    strobe(32'd4321);
    wait_idle(n);
    e = sb.pop_front();
    checks++;
    if ({dif.hex, dif.overflow} !== {e.hex, e.ovf} || n != 33) begin
      errors++; $display("FAIL mid_fresh: got %h/%b after %0d expected %h/%b after 33",
                         dif.hex, dif.overflow, n, e.hex, e.ovf);
    end
  endtask

  task automatic test_signed();
    int            n;
    exp_t          e;
    logic [HW-1:0] want;
`ifdef SIGNED_DISPLAY_EN
    want = {7'h40, 7'h40, 7'h40, 7'h12};
`else
    want = {7'h78, 7'h24, 7'h10, 7'h79};
`endif
    strobe(32'hFFFFFFFB);
    wait_idle(n);
    e = sb.pop_front();
    checks++;
    if (dif.hex !== want) begin
      errors++; $display("FAIL signed_hex: got %h expected %h", dif.hex, want);
    end
    checks++;
    if ({dif.overflow, dif.negative} !== {e.ovf, e.neg}) begin
      errors++; $display("FAIL signed_flags: got ovf/neg=%b%b expected %b%b",
                         dif.overflow, dif.negative, e.ovf, e.neg);
    end
    strobe(32'h80000000);
    wait_idle(n);
    e = sb.pop_front();
    checks++;
    if ({dif.hex, dif.overflow, dif.negative} !== {e.hex, e.ovf, e.neg}) begin
      errors++; $display("FAIL signed_min: got %h/%b%b expected %h/%b%b",
                         dif.hex, dif.overflow, dif.negative, e.hex, e.ovf, e.neg);
    end
  endtask

  initial begin
    dif.out  = 1'b0;
    dif.data = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_busy_strobe();
    test_back_to_back();
    test_reset_mid();
    test_signed();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
